// File: rtl/mips_pkg.sv
// Shared MIPS definitions: word width, opcodes, instruction classes and
// the fetch-stage types used by the instruction fetch unit and its queue.
package mips_pkg;

    localparam int WORD_W   = 32;
    localparam int OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPCODE_W-1:0] OP_AND   = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_OR    = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_SLT   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_MUL   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b001001;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OP_SUBI  = 6'b001011;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_BNEQZ = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_BEQZ  = 6'b001110;
    localparam logic [OPCODE_W-1:0] OP_HLT   = 6'b111111;

    typedef enum logic [2:0] {
        IT_RR_ALU,
        IT_RM_ALU,
        IT_LOAD,
        IT_STORE,
        IT_BRANCH,
        IT_HALT,
        IT_INVALID
    } instr_type_t;

    typedef enum logic [1:0] {
        FETCH,
        STALL,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] ir;
        logic [WORD_W-1:0] npc;
    } fetch_entry_t;

    function automatic instr_type_t instr_type_of(input logic [OPCODE_W-1:0] op);
        instr_type_t t;
        t = IT_INVALID;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = IT_RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                      t = IT_RM_ALU;
            OP_LW:                                          t = IT_LOAD;
            OP_SW:                                          t = IT_STORE;
            OP_BNEQZ, OP_BEQZ:                              t = IT_BRANCH;
            OP_HLT:                                         t = IT_HALT;
            default:                                        t = IT_INVALID;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mips_fetch_fifo.sv
// Prefetch queue between instruction fetch and decode: DEPTH entries of
// {ir, npc}, synchronous flush that overrides push and pop.
module mips_fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk1,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  fetch_entry_t            push_data,
    input  logic                    pop,
    output fetch_entry_t            head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    // A push into a full queue is only legal when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/mips_ifetch.sv
// Instruction fetch unit: issues one word fetch per cycle into a prefetch
// queue, handles taken-branch redirects, back-pressure stalls and halt.
module mips_ifetch
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk1,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    output logic [31:0] out_ir,
    output logic [31:0] out_npc,
    input  logic        out_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic              req_q;
    logic              req_d;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] addr_d;

    logic              flush;
    logic              push;
    logic              pop;
    fetch_entry_t      push_data;
    fetch_entry_t      head;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              full;
    logic              empty;

    // A redirect wins over everything in flight, except that a halted core ignores it.
    assign flush     = redirect && (state_q != HALTED);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready && !flush;
    assign push      = req_q && imem_ack && !flush && (!full || pop);
    assign push_data = '{ir: imem_rdata, npc: addr_q + 32'd1};

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign out_ir    = out_valid ? head.ir  : '0;
    assign out_npc   = out_valid ? head.npc : '0;

    mips_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            if (push) begin
                count_next = count_next + 1'b1;
            end
            if (pop) begin
                count_next = count_next - 1'b1;
            end
        end
    end

    // Requesting stays on exactly while the queue will have a free slot after this edge.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            HALTED: state_d = HALTED;
            default: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (count_next < DEPTH_C) begin
                    state_d = FETCH;
                end else begin
                    state_d = STALL;
                end
            end
        endcase
        req_d = (state_d == FETCH);
        if (flush) begin
            addr_d = redirect_pc;
        end else if (push) begin
            addr_d = addr_q + 32'd1;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_mips_ifetch.sv
// Self-checking bench for mips_ifetch: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_mips_ifetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic [31:0] out_ir;
    logic [31:0] out_npc;
    logic        out_ready;

    logic [31:0] mem [1024];
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] npc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_req;
    logic        m_halted;

    always #5 clk1 = ~clk1;

    assign imem_rdata = mem[imem_addr[9:0]];

    mips_ifetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .out_valid   (out_valid),
        .out_ir      (out_ir),
        .out_npc     (out_npc),
        .out_ready   (out_ready)
    );

    task automatic model_reset();
        mq.delete();
        m_pc     = RESET_PC;
        m_req    = 1'b0;
        m_halted = 1'b0;
    endtask

    // Reference behaviour for one rising edge, using the inputs as they stand.
    task automatic model_edge();
        logic acked;
        ent_t e;
        acked = m_req && imem_ack;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (redirect && !m_halted) begin
                mq.delete();
                m_pc = redirect_pc;
            end else begin
                if (out_ready && mq.size() > 0) begin
                    e = mq.pop_front();
                end
                if (acked) begin
                    e.ir  = mem[m_pc[9:0]];
                    e.npc = m_pc + 32'd1;
                    mq.push_back(e);
                    m_pc = m_pc + 32'd1;
                end
            end
            if (m_halted || halt) begin
                m_halted = 1'b1;
                m_req    = 1'b0;
            end else begin
                m_req = (mq.size() < DEPTH);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk1);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        redirect  = 1'b0;
        halt      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk1);
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got=%0b want=0", imem_req); end
        total++; if (imem_addr !== RESET_PC) begin bad++; $display("[TB] FAIL reset_addr got=%h want=%h", imem_addr, RESET_PC); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b want=0", out_valid); end
        total++; if (out_ir !== 32'h0) begin bad++; $display("[TB] FAIL reset_ir got=%h want=0", out_ir); end
        total++; if (out_npc !== 32'h0) begin bad++; $display("[TB] FAIL reset_npc got=%h want=0", out_npc); end
        rst_n = 1'b1;
        step();
        total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL reset_req_rise got=%0b want=1", imem_req); end
        total++; if (imem_addr !== RESET_PC) begin bad++; $display("[TB] FAIL reset_first_addr got=%h want=%h", imem_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_first_valid got=%0b want=0", out_valid); end
        for (int i = 0; i < 8; i++) begin
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_valid[%0d] got=%0b want=1", i, out_valid); end
            total++; if (out_ir !== mem[i]) begin bad++; $display("[TB] FAIL stream_ir[%0d] got=%h want=%h", i, out_ir, mem[i]); end
            total++; if (out_npc !== 32'(i + 1)) begin bad++; $display("[TB] FAIL stream_npc[%0d] got=%h want=%h", i, out_npc, 32'(i + 1)); end
            total++; if (imem_addr !== 32'(i + 1)) begin bad++; $display("[TB] FAIL stream_addr[%0d] got=%h want=%h", i, imem_addr, 32'(i + 1)); end
        end
    endtask

    task automatic test_backpressure();
        int acks;
        logic [31:0] exp_npc;
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req && imem_ack) acks++;
            step();
        end
        total++; if (acks !== DEPTH) begin bad++; $display("[TB] FAIL bp_ack_count got=%0d want=%0d", acks, DEPTH); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL bp_req_low got=%0b want=0", imem_req); end
        total++; if (out_npc !== 32'd1) begin bad++; $display("[TB] FAIL bp_head got=%h want=1", out_npc); end
        out_ready = 1'b1;
        exp_npc = 32'd1;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_npc = exp_npc + 32'd1;
            total++; if (out_npc !== exp_npc) begin bad++; $display("[TB] FAIL bp_resume_npc[%0d] got=%h want=%h", i, out_npc, exp_npc); end
            total++; if (out_ir !== mem[exp_npc[9:0] - 10'd1]) begin bad++; $display("[TB] FAIL bp_resume_ir[%0d] got=%h want=%h", i, out_ir, mem[exp_npc[9:0] - 10'd1]); end
        end
    endtask

    task automatic test_redirect_queued();
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b0;
        repeat (4) step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rq_pre_valid got=%0b want=1", out_valid); end
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rq_flush_valid got=%0b want=0", out_valid); end
        total++; if (imem_addr !== 32'h40) begin bad++; $display("[TB] FAIL rq_addr got=%h want=40", imem_addr); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL rq_req got=%0b want=1", imem_req); end
        out_ready = 1'b1;
        step();
        total++; if (out_npc !== 32'h41) begin bad++; $display("[TB] FAIL rq_first_npc got=%h want=41", out_npc); end
        total++; if (out_ir !== mem[10'h40]) begin bad++; $display("[TB] FAIL rq_first_ir got=%h want=%h", out_ir, mem[10'h40]); end
    endtask

    task automatic test_redirect_ack();
        logic found;
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (imem_addr === 32'd5) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("[TB] FAIL ra_reach_addr5 got=%h want=5", imem_addr); end
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ra_flush_valid got=%0b want=0", out_valid); end
        total++; if (imem_addr !== 32'h40) begin bad++; $display("[TB] FAIL ra_addr got=%h want=40", imem_addr); end
        step();
        total++; if (out_npc !== 32'h41) begin bad++; $display("[TB] FAIL ra_next_npc got=%h want=41", out_npc); end
        total++; if (out_ir !== mem[10'h40]) begin bad++; $display("[TB] FAIL ra_next_ir got=%h want=%h", out_ir, mem[10'h40]); end
    endtask

    task automatic test_halt();
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b0;
        repeat (3) step();
        imem_ack = 1'b0;
        halt     = 1'b1;
        step();
        halt = 1'b0;
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL halt_req got=%0b want=0", imem_req); end
        total++; if (out_npc !== 32'd1) begin bad++; $display("[TB] FAIL halt_head0 got=%h want=1", out_npc); end
        out_ready = 1'b1;
        step();
        total++; if (out_npc !== 32'd2) begin bad++; $display("[TB] FAIL halt_head1 got=%h want=2", out_npc); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_drained got=%0b want=0", out_valid); end
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        imem_ack    = 1'b1;
        step();
        redirect = 1'b0;
        step();
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL halt_redir_req got=%0b want=0", imem_req); end
        total++; if (imem_addr !== 32'd2) begin bad++; $display("[TB] FAIL halt_redir_addr got=%h want=2", imem_addr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_redir_valid got=%0b want=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b0;
        repeat (3) step();
        imem_ack = 1'b0;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL mid_req got=%0b want=0", imem_req); end
        total++; if (imem_addr !== RESET_PC) begin bad++; $display("[TB] FAIL mid_addr got=%h want=%h", imem_addr, RESET_PC); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid got=%0b want=0", out_valid); end
        total++; if (out_npc !== 32'h0) begin bad++; $display("[TB] FAIL mid_npc got=%h want=0", out_npc); end
        @(posedge clk1);
        #1;
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin bad++; $display("[TB] FAIL mid_restart got=%0b/%h want=1/%h", imem_req, imem_addr, RESET_PC); end
        step();
        total++; if (out_npc !== RESET_PC + 32'd1) begin bad++; $display("[TB] FAIL mid_first_npc got=%h want=%h", out_npc, RESET_PC + 32'd1); end
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL wrap_addr got=%h want=ffffffff", imem_addr); end
        step();
        total++; if (out_npc !== 32'h0) begin bad++; $display("[TB] FAIL wrap_npc got=%h want=0", out_npc); end
        total++; if (out_ir !== mem[10'h3FF]) begin bad++; $display("[TB] FAIL wrap_ir got=%h want=%h", out_ir, mem[10'h3FF]); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL wrap_next_addr got=%h want=0", imem_addr); end
    endtask

    task automatic test_random();
        logic        e_valid;
        logic [31:0] e_ir;
        logic [31:0] e_npc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            imem_ack    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            step();
            e_valid = (mq.size() != 0);
            e_ir    = e_valid ? mq[0].ir  : 32'h0;
            e_npc   = e_valid ? mq[0].npc : 32'h0;
            total++; if (imem_req !== m_req) begin bad++; $display("[TB] FAIL rnd_req[%0d] got=%0b want=%0b", i, imem_req, m_req); end
            total++; if (imem_addr !== m_pc) begin bad++; $display("[TB] FAIL rnd_addr[%0d] got=%h want=%h", i, imem_addr, m_pc); end
            total++; if (out_valid !== e_valid) begin bad++; $display("[TB] FAIL rnd_valid[%0d] got=%0b want=%0b", i, out_valid, e_valid); end
            total++; if (out_ir !== e_ir) begin bad++; $display("[TB] FAIL rnd_ir[%0d] got=%h want=%h", i, out_ir, e_ir); end
            total++; if (out_npc !== e_npc) begin bad++; $display("[TB] FAIL rnd_npc[%0d] got=%h want=%h", i, out_npc, e_npc); end
        end
        redirect = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_queued();
        test_redirect_ack();
        test_halt();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_ifetch.md
MIPS_IFETCH -- requirements
Module: mips_ifetch

Interface
REQ-001 Parameter DEPTH, default 4: prefetch queue entries, power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset (word address).
REQ-003 clk1  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word address of current request; memory indexes the low 10 bits.
REQ-007 imem_ack  input  1  request accepted; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect  input  1  taken branch from EX/MEM; single-cycle pulse.
REQ-010 redirect_pc  input  32  branch target, sampled when redirect=1.
REQ-011 halt  input  1  HLT retired; stop fetching.
REQ-012 out_valid  output  1  queue head holds a valid instruction.
REQ-013 out_ir  output  32  head instruction word, to the IF/ID register.
REQ-014 out_npc  output  32  head fetch address + 1.
REQ-015 out_ready  input  1  decode consumes the head this cycle.

Function
REQ-016 The FSM SHALL have states FETCH (imem_req=1), STALL (imem_req=0, queue has no free slot) and HALTED (imem_req=0, terminal until reset).
REQ-017 At most one request SHALL be outstanding; imem_req and imem_addr SHALL stay stable until an edge with imem_ack=1.
REQ-018 On an ack edge, {imem_rdata, imem_addr+1} SHALL be pushed and imem_addr SHALL advance by 1; imem_req SHALL stay high if a slot remains free, giving one fetch per cycle with no bubble.
REQ-019 Free-slot check: entries + pushes this edge - pops this edge < DEPTH; the queue SHALL never overflow, and FETCH↔STALL SHALL follow this check.
REQ-020 out_valid = (count != 0), driven from registers; out_ir and out_npc SHALL be the head entry, with out_ir=0 and out_npc=0 when the queue is empty.
REQ-021 A pop SHALL occur on an edge with out_valid=1 and out_ready=1; simultaneous push and pop SHALL leave count unchanged.
REQ-022 Latency: data acked at edge N SHALL be visible on out_* after edge N, if the queue was empty.
REQ-023 On redirect, the queue SHALL flush at that edge, imem_addr SHALL load redirect_pc, and out_valid SHALL be 0 in the following cycle.
REQ-024 Redirect SHALL take priority over a simultaneous push, pop or stall, and the acked word in that cycle SHALL be discarded.
REQ-025 Redirect SHALL NOT drop an outstanding unacked request: imem_addr SHALL switch to redirect_pc while imem_req stays high.
REQ-026 On halt=1, the FSM SHALL enter HALTED and drop imem_req on the next edge; queued entries SHALL still drain to decode.
REQ-027 Redirect SHALL be ignored in HALTED.
REQ-028 Address arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFF + 1 = 0.

Reset
REQ-029 While rst_n=0: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_ir=0, out_npc=0, count=0, state FETCH.
REQ-030 Assertion of rst_n mid-request SHALL abandon the request without waiting for ack.
REQ-031 imem_req SHALL rise at the first clk1 edge after rst_n deasserts.

Structure
REQ-032 Opcode constants, instruction-type codes and word width SHALL live in shared package mips_pkg.
REQ-033 The queue SHALL be sub-module mips_fetch_fifo: synchronous flush, push/pop, count, full/empty, parameterised by DEPTH.

Verification
REQ-034 Reset, ack tied high, out_ready high: imem_addr 0,1,2,...; out_ir follows Mem[0],Mem[1],...; out_npc 1,2,3 at one per cycle.
REQ-035 out_ready=0, ack high, DEPTH=4: exactly 4 acks, then imem_req=0; raising out_ready resumes fetch with no lost or duplicated word.
REQ-036 Redirect to 32'h40 with 3 entries queued: out_valid=0 next cycle, imem_addr=32'h40, first output out_npc=32'h41.
REQ-037 Redirect in the same cycle as ack of word at address 5: that word is never output; next output comes from 32'h40.
REQ-038 halt with 2 entries queued: imem_req falls next edge, both entries drain, then out_valid stays 0; a later redirect is ignored.
REQ-039 rst_n pulsed low while imem_req=1 and ack withheld: outputs return to reset values asynchronously, and fetch restarts at RESET_PC.
